// File: rtl/dmem_pkg.sv
// Shared constants and types for the port-B burst reader (dmem_burst_reader).
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W     = 16;
    localparam int unsigned DMEM_DATA_W     = 8;
    localparam int unsigned DMEM_FIFO_DEPTH = 4;
    // Width of occupancy and credit counters; covers FIFO depths up to 255.
    localparam int unsigned DMEM_OCC_W      = 8;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } dmem_rd_state_t;

endpackage

// File: rtl/dmem_rd_fifo.sv
// Synchronous show-ahead return buffer with flush; the head entry sits in a
// dedicated output register so the stream outputs come straight from flops.
module dmem_rd_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [DMEM_OCC_W-1:0] r_cnt;
    logic                  r_valid;
    logic [WIDTH-1:0]      r_data;

    logic w_load;
    logic w_push;

    // Refill the output register whenever it is empty or being consumed.
    assign w_load = (!r_valid || i_rd_en) && (r_cnt != '0) && !i_flush;
    assign w_push = i_wr_en && !i_flush &&
                    ((r_cnt != DMEM_OCC_W'(DEPTH)) || w_load);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_load) begin
                r_data  <= r_mem[r_rptr];
                r_valid <= 1'b1;
                r_rptr  <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
            end else if (i_rd_en) begin
                r_valid <= 1'b0;
            end
            r_cnt <= r_cnt + DMEM_OCC_W'(w_push) - DMEM_OCC_W'(w_load);
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/dmem_burst_reader.sv
// Sequential byte-read engine on data-memory port B feeding a valid/ready stream.
// Optional running checksum output is enabled with DMEM_READER_CHECKSUM_EN.
module dmem_burst_reader
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DMEM_ADDR_W,
    parameter int unsigned DATA_W     = DMEM_DATA_W,
    parameter int unsigned READ_LAT   = 2,
    parameter int unsigned FIFO_DEPTH = DMEM_FIFO_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_length,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_ram_addr,
    input  logic [DATA_W-1:0] i_ram_q,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_last
`ifdef DMEM_READER_CHECKSUM_EN
    ,
    output logic [15:0]       o_checksum
`endif
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    dmem_rd_state_t r_state;
    dmem_rd_state_t w_state_d;

    logic [ADDR_W-1:0]     r_ram_addr;
    logic [ADDR_W-1:0]     r_next_addr;
    logic [LEN_W-1:0]      r_remaining;
    logic [DMEM_OCC_W-1:0] r_credit;
    logic                  r_busy;
    logic [READ_LAT-1:0]   r_tag_vld;
    logic [READ_LAT-1:0]   r_tag_last;

    logic              w_accept;
    logic              w_flush;
    logic              w_pop;
    logic              w_has_credit;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_fifo_wr;
    logic              w_fifo_valid;
    logic [DATA_W:0]   w_fifo_data;

    assign w_accept = (r_state == StIdle) && i_start && !i_abort;
    assign w_flush  = (r_state != StIdle) && i_abort;
    assign w_pop    = w_fifo_valid && i_out_ready;

    // Credit covers reads in flight plus buffered bytes; a byte leaving this
    // cycle frees its slot early so a FIFO of READ_LAT+2 sustains full rate.
    assign w_has_credit = (r_credit < DMEM_OCC_W'(FIFO_DEPTH)) || w_pop;
    assign w_issue      = (r_state == StIssue) && !i_abort &&
                          (r_remaining != '0) && w_has_credit;
    assign w_issue_last = w_issue && (r_remaining == LEN_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        o_done    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start && !i_abort) begin
                    w_state_d = (i_length == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (i_abort) begin
                    w_state_d = StIdle;
                end else if (w_issue_last) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (i_abort) begin
                    w_state_d = StIdle;
                end else if (w_pop && w_fifo_data[DATA_W]) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                o_done    = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ram_addr  <= '0;
            r_next_addr <= '0;
            r_remaining <= '0;
            r_credit    <= '0;
            r_busy      <= 1'b0;
            r_tag_vld   <= '0;
            r_tag_last  <= '0;
        end else begin
            if (w_accept) begin
                r_next_addr <= i_base_addr;
                r_remaining <= i_length;
            end else if (w_issue) begin
                r_ram_addr  <= r_next_addr;
                r_next_addr <= r_next_addr + ADDR_W'(1);
                r_remaining <= r_remaining - LEN_W'(1);
            end

            if (w_flush) begin
                r_credit <= '0;
            end else begin
                r_credit <= r_credit + DMEM_OCC_W'(w_issue) - DMEM_OCC_W'(w_pop);
            end

            if (w_flush || (r_state == StDone)) begin
                r_busy <= 1'b0;
            end else if (w_accept && (i_length != '0)) begin
                r_busy <= 1'b1;
            end

            if (w_flush) begin
                r_tag_vld  <= '0;
                r_tag_last <= '0;
            end else begin
                r_tag_vld[0]  <= w_issue;
                r_tag_last[0] <= w_issue_last;
                for (int unsigned i = 1; i < READ_LAT; i++) begin
                    r_tag_vld[i]  <= r_tag_vld[i-1];
                    r_tag_last[i] <= r_tag_last[i-1];
                end
            end
        end
    end

    assign w_fifo_wr = r_tag_vld[READ_LAT-1] && !w_flush;

    dmem_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_flush   (w_flush),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data ({r_tag_last[READ_LAT-1], i_ram_q}),
        .i_rd_en   (w_pop),
        .o_valid   (w_fifo_valid),
        .o_data    (w_fifo_data)
    );

    assign o_busy      = r_busy;
    assign o_ram_addr  = r_ram_addr;
    assign o_out_valid = w_fifo_valid;
    assign o_out_data  = w_fifo_data[DATA_W-1:0];
    assign o_out_last  = w_fifo_valid && w_fifo_data[DATA_W];

`ifdef DMEM_READER_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + 16'(o_out_data);
        end
    end

    assign o_checksum = r_checksum;
`endif

endmodule

// File: tb/tb_dmem_burst_reader.sv
// Directed bench for dmem_burst_reader with a behavioural port-B RAM model.
module tb_dmem_burst_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] base_addr;
    logic [16:0] length;
    logic        busy;
    logic        done;
    logic [15:0] ram_addr;
    logic [7:0]  ram_q;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
`ifdef DMEM_READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic [7:0] mem [65536];
    int n_pass  = 0;
    int n_total = 0;

    dmem_burst_reader dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_abort     (abort),
        .i_base_addr (base_addr),
        .i_length    (length),
        .o_busy      (busy),
        .o_done      (done),
        .o_ram_addr  (ram_addr),
        .i_ram_q     (ram_q),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_last  (out_last)
`ifdef DMEM_READER_CHECKSUM_EN
        ,
        .o_checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    // One registered stage: data follows the address update by one edge.
    always @(posedge clk) ram_q <= mem[ram_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_byte(input logic [15:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [15:0] b, input logic [16:0] l);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        base_addr = '0; length = '0;
        repeat (3) tick();
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_last !== 1'b0) $display("FAIL reset_last: got %b want 0", out_last); else n_pass++;
        n_total++; if (out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", out_data); else n_pass++;
        n_total++; if (ram_addr !== 16'h0000) $display("FAIL reset_addr: got %h want 0000", ram_addr); else n_pass++;
`ifdef DMEM_READER_CHECKSUM_EN
        n_total++; if (checksum !== 16'h0000) $display("FAIL reset_cksum: got %h want 0000", checksum); else n_pass++;
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int first_valid = -1, first_beat = -1, last_beat = -1, done_t = -1;
        int beats = 0, done_cnt = 0;
        out_ready = 1'b1;
        start_burst(16'h0010, 17'd8);
        n_total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (out_valid === 1'b1 && first_valid < 0) first_valid = t;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_total++;
                if (out_data !== exp_byte(16'h0010 + 16'(beats)))
                    $display("FAIL basic_data beat %0d: got %h want %h", beats, out_data,
                             exp_byte(16'h0010 + 16'(beats)));
                else n_pass++;
                n_total++;
                if (out_last !== (beats == 7))
                    $display("FAIL basic_last beat %0d: got %b want %b", beats, out_last, beats == 7);
                else n_pass++;
                if (first_beat < 0) first_beat = t;
                last_beat = t;
                beats++;
            end
        end
        n_total++; if (first_valid != 4) $display("FAIL basic_latency: got %0d want 4", first_valid); else n_pass++;
        n_total++; if (beats != 8) $display("FAIL basic_count: got %0d want 8", beats); else n_pass++;
        n_total++; if (last_beat - first_beat != 7) $display("FAIL basic_bubbles: span %0d want 7", last_beat - first_beat); else n_pass++;
        n_total++; if (done_t != last_beat + 1) $display("FAIL basic_done_time: got %0d want %0d", done_t, last_beat + 1); else n_pass++;
        n_total++; if (done_cnt != 1) $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        int beats = 0, issued = 0, max_out = 0, stable_viol = 0, done_cnt = 0;
        logic [15:0] prev_addr;
        logic        hold_valid = 1'b0;
        logic [7:0]  hold_data = '0;
        logic        hold_last = 1'b0;
        out_ready = 1'b0;
        prev_addr = ram_addr;
        start_burst(16'h0040, 17'd16);
        for (int t = 1; t <= 150; t++) begin
            tick();
            out_ready = (t % 3 == 0);
            // A start while busy must be ignored.
            start = (t == 2);
            if (t == 2) begin
                base_addr = 16'h0300;
                length    = 17'd1;
            end
            if (done === 1'b1) done_cnt++;
            if (ram_addr !== prev_addr) issued++;
            prev_addr = ram_addr;
            if (issued - beats > max_out) max_out = issued - beats;
            if (hold_valid && !(out_valid === 1'b1 && out_data === hold_data && out_last === hold_last))
                stable_viol++;
            hold_valid = 1'b0;
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                hold_valid = 1'b1;
                hold_data  = out_data;
                hold_last  = out_last;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_total++;
                if (out_data !== exp_byte(16'h0040 + 16'(beats)))
                    $display("FAIL bp_data beat %0d: got %h want %h", beats, out_data,
                             exp_byte(16'h0040 + 16'(beats)));
                else n_pass++;
                n_total++;
                if (out_last !== (beats == 15))
                    $display("FAIL bp_last beat %0d: got %b want %b", beats, out_last, beats == 15);
                else n_pass++;
                beats++;
            end
        end
        start = 1'b0;
        n_total++; if (beats != 16) $display("FAIL bp_count: got %0d want 16", beats); else n_pass++;
        n_total++; if (issued != 16) $display("FAIL bp_issued: got %0d want 16", issued); else n_pass++;
        n_total++; if (max_out != 4) $display("FAIL bp_credit: max outstanding %0d want 4", max_out); else n_pass++;
        n_total++; if (stable_viol != 0) $display("FAIL bp_stable: got %0d violations want 0", stable_viol); else n_pass++;
        n_total++; if (done_cnt != 1) $display("FAIL bp_done: got %0d pulses want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [15:0] exp_addr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        logic [7:0]  exp_data [4] = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
        logic [15:0] seen [8];
        logic [15:0] prev_addr;
        int n_addr = 0, beats = 0;
        out_ready = 1'b1;
        prev_addr = ram_addr;
        start_burst(16'hFFFE, 17'd4);
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (ram_addr !== prev_addr && n_addr < 8) begin
                seen[n_addr] = ram_addr;
                n_addr++;
            end
            prev_addr = ram_addr;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_total++;
                if (beats >= 4 || out_data !== exp_data[beats % 4])
                    $display("FAIL wrap_data beat %0d: got %h want %h", beats, out_data, exp_data[beats % 4]);
                else n_pass++;
                beats++;
            end
        end
        n_total++; if (n_addr != 4) $display("FAIL wrap_addr_count: got %0d want 4", n_addr); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (seen[i] !== exp_addr[i])
                $display("FAIL wrap_addr %0d: got %h want %h", i, seen[i], exp_addr[i]);
            else n_pass++;
        end
        n_total++; if (beats != 4) $display("FAIL wrap_count: got %0d want 4", beats); else n_pass++;
    endtask

    task automatic test_zero_len();
        int valid_cnt = 0, busy_cnt = 0, done_cnt = 0;
        logic [15:0] prev_addr;
        out_ready = 1'b1;
        prev_addr = ram_addr;
        start_burst(16'h1234, 17'd0);
        n_total++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else n_pass++;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (out_valid !== 1'b0) valid_cnt++;
            if (busy !== 1'b0) busy_cnt++;
            if (done !== 1'b0) done_cnt++;
        end
        n_total++; if (valid_cnt != 0) $display("FAIL zero_valid: got %0d cycles want 0", valid_cnt); else n_pass++;
        n_total++; if (busy_cnt != 0) $display("FAIL zero_busy_later: got %0d cycles want 0", busy_cnt); else n_pass++;
        n_total++; if (done_cnt != 0) $display("FAIL zero_extra_done: got %0d want 0", done_cnt); else n_pass++;
        n_total++; if (ram_addr !== prev_addr) $display("FAIL zero_addr: got %h want %h", ram_addr, prev_addr); else n_pass++;
    endtask

    task automatic test_abort();
        int bad = 0, beats = 0;
        out_ready = 1'b0;
        start_burst(16'h0020, 17'd10);
        repeat (5) tick();
        n_total++; if (out_valid !== 1'b1) $display("FAIL abort_pre_valid: got %b want 1", out_valid); else n_pass++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done); else n_pass++;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (done !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL abort_quiet: got %0d bad cycles want 0", bad); else n_pass++;
        out_ready = 1'b1;
        start_burst(16'h0100, 17'd2);
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_total++;
                if (out_data !== exp_byte(16'h0100 + 16'(beats)))
                    $display("FAIL abort_next_data beat %0d: got %h want %h", beats, out_data,
                             exp_byte(16'h0100 + 16'(beats)));
                else n_pass++;
                beats++;
            end
        end
        n_total++; if (beats != 2) $display("FAIL abort_next_count: got %0d want 2", beats); else n_pass++;
    endtask

    task automatic test_abort_start_idle();
        int bad = 0;
        logic [15:0] prev_addr;
        out_ready = 1'b1;
        prev_addr = ram_addr;
        abort = 1'b1;
        start_burst(16'h0200, 17'd3);
        abort = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL idle_abort_busy: got %b want 0", busy); else n_pass++;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL idle_abort_quiet: got %0d bad cycles want 0", bad); else n_pass++;
        n_total++; if (ram_addr !== prev_addr) $display("FAIL idle_abort_addr: got %h want %h", ram_addr, prev_addr); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        out_ready = 1'b0;
        start_burst(16'h0600, 17'd12);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 8'h00) $display("FAIL rstmid_data: got %h want 00", out_data); else n_pass++;
        n_total++; if (ram_addr !== 16'h0000) $display("FAIL rstmid_addr: got %h want 0000", ram_addr); else n_pass++;
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        start_burst(16'h0700, 17'd1);
        for (int t = 1; t <= 15; t++) begin
            tick();
            if (out_valid === 1'b1) begin
                n_total++;
                if (out_data !== 8'hA5 || out_last !== 1'b1)
                    $display("FAIL rstmid_recover: got %h/%b want a5/1", out_data, out_last);
                else n_pass++;
                beats++;
            end
        end
        n_total++; if (beats != 1) $display("FAIL rstmid_count: got %0d want 1", beats); else n_pass++;
    endtask

`ifdef DMEM_READER_CHECKSUM_EN
    task automatic test_checksum();
        int seen_done = 0;
        mem[16'h0800] = 8'h01;
        mem[16'h0801] = 8'h02;
        mem[16'h0802] = 8'h03;
        mem[16'h0803] = 8'hFF;
        out_ready = 1'b1;
        start_burst(16'h0800, 17'd4);
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (done === 1'b1) begin
                seen_done++;
                n_total++;
                if (checksum !== 16'h0105) $display("FAIL cksum_value: got %h want 0105", checksum);
                else n_pass++;
            end
        end
        n_total++; if (seen_done != 1) $display("FAIL cksum_done: got %0d want 1", seen_done); else n_pass++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'hA5;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_abort();
        test_abort_start_idle();
        test_reset_mid();
`ifdef DMEM_READER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_burst_reader.md
# dmem_burst_reader

Streaming read engine on port B of the 64K×8 data memory (`RamDataMem`). On a start command it issues sequential byte reads from a base address and absorbs the RAM's fixed read latency in a small buffer. It delivers the bytes on a valid/ready stream to the downstream processing stage. Port B is therefore read-only from this block; `wren_b` is tied low at the top level.

## Interface
- `ADDR_W`, 16: RAM address width.
- `DATA_W`, 8: RAM data width.
- `READ_LAT`, 2: cycles from `ram_addr` presented to `ram_q` valid.
- `FIFO_DEPTH`, 4: return-buffer entries; must be ≥ `READ_LAT`+2 for full throughput.

Ports:
- `clk`  in  1  single clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  command strobe; accepted only in IDLE.
- `abort`  in  1  cancel current burst.
- `base_addr`  in  ADDR_W  first byte address, sampled on accepted start.
- `length`  in  ADDR_W+1  byte count, 0..65536, sampled on accepted start.
- `busy`  out  1  high from the cycle after accept until return to IDLE.
- `done`  out  1  one-cycle pulse at burst completion.
- `ram_addr`  out  ADDR_W  to RAM `address_b`.
- `ram_q`  in  DATA_W  from RAM `q_b`.
- `out_data`  out  DATA_W  stream byte.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_last`  out  1  marks the final byte of the burst.
- `checksum`  out  16  present only with the macro; see Configuration.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE: `start`=1 and `length`≠0. Latch `base_addr` and `length`.
- IDLE → DONE: `start`=1 and `length`=0. No reads are issued.
- ISSUE: issue one read per cycle while `remaining` > 0 and in-flight count + FIFO occupancy < `FIFO_DEPTH`.
  - On each issue, `ram_addr` increments.
  - Wrap-around: address 0xFFFF is followed by 0x0000.
- ISSUE → DRAIN: after the last issue.
- DRAIN → DONE: on the handshake (`out_valid`&`out_ready`) of the byte carrying `out_last`.
- DONE → IDLE: unconditionally. `done`=1 only while in DONE.
- In-flight tracking: a `READ_LAT`-deep valid shift register. When a tagged read returns, `ram_q` is written to the FIFO. The FIFO never overflows because of the credit rule above.
- `out_last`: asserted with the byte whose issue index is `length`−1.
- `abort` in any non-IDLE state:
  - Next cycle: FIFO flushed, in-flight tags cleared, state IDLE.
  - `out_valid`=0 and no `done` pulse.
- `start` while `busy`: ignored.
- `abort` and `start` in the same cycle while in IDLE: `abort` wins, so the start is not accepted.
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `ram_addr`=0, `checksum`=0, state IDLE, FIFO empty.
- Reset mid-burst behaves as an abort and applies the reset values.

## Timing
- `start` accepted at edge k:
  - `ram_addr`=`base_addr` after edge k+1.
  - Data captured into the FIFO at edge k+1+`READ_LAT`.
  - `out_valid` high after edge k+2+`READ_LAT` (k+4 with defaults).
- With `out_ready` held high: one byte per cycle, no bubbles.
- `done` pulses in the cycle after the last handshake.
- Backpressure:
  - Issue stalls within one cycle of the FIFO credit running out.
  - `out_data` and `out_last` stay stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- Macro: `DMEM_READER_CHECKSUM_EN`.
- Defined:
  - 16-bit `checksum` port, cleared on accepted start.
  - Adds the zero-extended `out_data` on each handshake, modulo 2^16.
  - Final value is valid while `done`=1 and holds until the next accepted start.
- Undefined: the port and the accumulator are absent. All other behaviour is identical.

## Structure
- Package `dmem_pkg`:
  - `ADDR_W`/`DATA_W` constants.
  - `dmem_rd_state_t` enum (IDLE, ISSUE, DRAIN, DONE).
  - Occupancy/credit width constant.
- Sub-module `dmem_rd_fifo`: synchronous show-ahead FIFO with `FIFO_DEPTH` entries, a flush input, and a registered output.
- The FSM, address counter, remaining counter and latency tag pipeline live in the top module.

## Test plan
Preload RAM with mem[i] = i[7:0] ^ 0xA5.
- base=0x0010, len=8, ready=1:
  - Bytes 0xB5..0xB2 (mem[0x10..0x17]) in order.
  - First `out_valid` 4 cycles after start, 8 consecutive beats.
  - `out_last` on beat 8, `done` on the following cycle.
- base=0x0040, len=16, `out_ready` high 1 cycle in 3:
  - Exactly 16 correct bytes, no duplicates.
  - `ram_addr` stalls when the FIFO is full, with no overflow.
- base=0xFFFE, len=4:
  - `ram_addr` sequence FFFE, FFFF, 0000, 0001.
  - Bytes 0x5B, 0x5A, 0xA5, 0xA4.
- len=0: `done` one cycle after start, `out_valid` never asserted, `busy` stays 0.
- Abort case:
  - base=0x0020, len=10, `out_ready`=0, `abort` 6 cycles after start: next cycle `out_valid`=0, `busy`=0, no `done`.
  - Then start base=0x0100, len=2: only mem[0x100] and mem[0x101] are delivered.
- With `DMEM_READER_CHECKSUM_EN`, RAM bytes 01, 02, 03, FF, len=4: `checksum`=0x0105 while `done` is high.
